// File: rtl/y_round_robin.sv
// y_round_robin: registered round-robin row arbiter with rotating priority pointer; optional gnt_valid_o under Y_RR_GNT_VALID_EN
module y_round_robin #(
  parameter int WIDTH = 8,
  parameter int y_width = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic [WIDTH-1:0]   req_i,
  output logic [WIDTH-1:0]   gnt_o,
  output logic [y_width-1:0] yadd_o
`ifdef Y_RR_GNT_VALID_EN
  ,
  output logic               gnt_valid_o
`endif
);
  logic [y_width-1:0] ptr, hi_w, lo_w, win, nxt_ptr;
  logic [WIDTH-1:0]   hi;
  logic               fire;
  // Requests at or above ptr win first; otherwise fall back to the lowest request overall.
  always_comb begin
    hi = '0;
    hi_w = '0;
    lo_w = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      hi[i] = req_i[i] && (i >= int'(ptr));
      if (req_i[i]) lo_w = y_width'(i);
      if (hi[i]) hi_w = y_width'(i);
    end
    win = |hi ? hi_w : lo_w;
    nxt_ptr = (win == y_width'(WIDTH - 1)) ? '0 : win + 1'b1;
    fire = enable_i && |req_i;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      gnt_o <= '0;
      yadd_o <= '0;
      ptr <= '0;
    end else begin
      gnt_o <= fire ? WIDTH'(1) << win : '0;
      yadd_o <= fire ? win : yadd_o;
      ptr <= fire ? nxt_ptr : ptr;
    end
  end
`ifdef Y_RR_GNT_VALID_EN
  always_ff @(posedge clk_i) gnt_valid_o <= !reset_i && fire;
`endif
endmodule

// File: tb/tb_y_round_robin.sv
// tb_y_round_robin: table-driven vectors through a scoreboard queue, plus reset/fairness sequences
module tb_y_round_robin;
  logic       clk = 0;
  logic       reset_i = 1, enable_i = 0;
  logic [7:0] req_i = '0;
  logic [7:0] gnt_o;
  logic [2:0] yadd_o;
  int checks = 0, errors = 0;
`ifdef Y_RR_GNT_VALID_EN
  logic gnt_valid_o;
`endif

  y_round_robin #(.WIDTH(8), .y_width(3)) dut (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .req_i(req_i),
    .gnt_o(gnt_o), .yadd_o(yadd_o)
`ifdef Y_RR_GNT_VALID_EN
    , .gnt_valid_o(gnt_valid_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic rst; logic en; logic [7:0] req; logic [7:0] gnt; logic [2:0] y;} vec_t;
  typedef struct {logic [7:0] gnt; logic [2:0] y; string nm;} exp_t;
  vec_t tv[29];
  exp_t sb[$];
  int cnt[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic [7:0] req,
                      input logic [7:0] gnt, input logic [2:0] y, input string nm);
    exp_t e;
    @(negedge clk);
    reset_i = rst;
    enable_i = en;
    req_i = req;
    sb.push_back('{gnt, y, nm});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.nm, ".gnt"}, 32'(gnt_o), 32'(e.gnt));
    check({e.nm, ".yadd"}, 32'(yadd_o), 32'(e.y));
`ifdef Y_RR_GNT_VALID_EN
    check({e.nm, ".valid"}, 32'(gnt_valid_o), 32'(e.gnt != 0));
`endif
  endtask

  initial begin
    tv[0]  = '{1, 1, 8'hEF, 8'h00, 3'd0};
    tv[1]  = '{0, 1, 8'h93, 8'h01, 3'd0};
    tv[2]  = '{0, 1, 8'h93, 8'h02, 3'd1};
    tv[3]  = '{0, 1, 8'h93, 8'h10, 3'd4};
    tv[4]  = '{0, 1, 8'h93, 8'h80, 3'd7};
    tv[5]  = '{0, 1, 8'h93, 8'h01, 3'd0};
    tv[6]  = '{0, 1, 8'h93, 8'h02, 3'd1};
    tv[7]  = '{0, 1, 8'h93, 8'h10, 3'd4};
    tv[8]  = '{0, 1, 8'h64, 8'h20, 3'd5};
    tv[9]  = '{0, 1, 8'h64, 8'h40, 3'd6};
    tv[10] = '{0, 1, 8'h64, 8'h04, 3'd2};
    tv[11] = '{0, 1, 8'h64, 8'h20, 3'd5};
    tv[12] = '{0, 0, 8'hE2, 8'h00, 3'd5};
    tv[13] = '{0, 1, 8'hEF, 8'h40, 3'd6};
    tv[14] = '{0, 1, 8'hEF, 8'h80, 3'd7};
    tv[15] = '{0, 1, 8'hEF, 8'h01, 3'd0};
    tv[16] = '{1, 1, 8'hEF, 8'h00, 3'd0};
    tv[17] = '{0, 1, 8'hF2, 8'h02, 3'd1};
    tv[18] = '{0, 1, 8'hF2, 8'h10, 3'd4};
    tv[19] = '{0, 1, 8'hF2, 8'h20, 3'd5};
    tv[20] = '{0, 1, 8'hF2, 8'h40, 3'd6};
    tv[21] = '{0, 1, 8'hF2, 8'h80, 3'd7};
    tv[22] = '{0, 1, 8'h10, 8'h10, 3'd4};
    tv[23] = '{0, 1, 8'h10, 8'h10, 3'd4};
    tv[24] = '{0, 1, 8'h10, 8'h10, 3'd4};
    tv[25] = '{0, 1, 8'h01, 8'h01, 3'd0};
    tv[26] = '{0, 1, 8'h01, 8'h01, 3'd0};
    tv[27] = '{0, 1, 8'h00, 8'h00, 3'd0};
    tv[28] = '{0, 0, 8'hFF, 8'h00, 3'd0};
    for (int i = 0; i < 29; i++)
      step(tv[i].rst, tv[i].en, tv[i].req, tv[i].gnt, tv[i].y, $sformatf("vec%0d", i));
    step(1, 0, 8'h00, 8'h00, 3'd0, "fair_rst");
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'hFF, 8'(1) << (i % 8), 3'(i % 8), $sformatf("fair%0d", i));
      check($sformatf("onehot%0d", i), 32'(gnt_o), 32'(8'(1) << yadd_o));
      cnt[yadd_o]++;
    end
    for (int i = 0; i < 8; i++) check($sformatf("count%0d", i), 32'(cnt[i]), 32'd2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
